// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_core
// Brief    : Multicycle MIPS subset core (FETCH/DECODE/EXECUTE/WRITEBACK/HALT)
//            with memory-mapped I/O: sw 0xFFFF_0000 -> port_out,
//            lw 0xFFFF_0004 <- port_in.
//            Define MIPS_MC_PORTIN_SYNC_EN to sample port_in through a
//            two-flop synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_core #(
    parameter int          MEMORY_DEPTH  = 32,
    parameter int          PORT_IN_WIDTH = 8,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    output logic [31:0]              instr_addr,
    input  logic [31:0]              instr_data,
    input  logic [PORT_IN_WIDTH-1:0] port_in,
    output logic [31:0]              port_out,
    output logic [31:0]              alu_result_out,
    output logic                     halted
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [5:0]  c_OP_RTYPE = 6'h00, c_OP_J   = 6'h02, c_OP_BEQ = 6'h04,
                            c_OP_BNE   = 6'h05, c_OP_ADDI = 6'h08, c_OP_ORI = 6'h0D,
                            c_OP_LUI   = 6'h0F, c_OP_LW  = 6'h23, c_OP_SW  = 6'h2B;
    localparam logic [5:0]  c_FN_SLL = 6'h00, c_FN_SRL = 6'h02, c_FN_ADD = 6'h20,
                            c_FN_SUB = 6'h22, c_FN_AND = 6'h24, c_FN_OR  = 6'h25,
                            c_FN_SLT = 6'h2A;
    localparam logic [31:0] c_PORT_OUT_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] c_PORT_IN_ADDR  = 32'hFFFF_0004;
    localparam logic [31:0] c_DEPTH         = 32'(MEMORY_DEPTH);

    state_t      r_state_q;
    logic [31:0] r_pc_q, r_ir_q, r_a_q, r_b_q, r_imm_q, r_alu_q, r_port_out_q;
    logic        r_halted_q;
    logic [31:0] r_rf_q [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [31:0] w_pc4, w_alu_d, w_pc_d, w_wb_data, w_port_val;
    logic        w_is_branch, w_r_ok, w_wb_en, w_pc_oor;
    logic [4:0]  w_wb_addr;

`ifdef MIPS_MC_PORTIN_SYNC_EN
    logic [PORT_IN_WIDTH-1:0] r_sync1_q, r_sync2_q;

    // Synchroniser keeps sampling while the core is frozen by run = 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
        end else begin
            r_sync1_q <= port_in;
            r_sync2_q <= r_sync1_q;
        end
    end
    assign w_port_val = 32'(r_sync2_q);
`else
    assign w_port_val = 32'(port_in);
`endif

    assign w_op     = r_ir_q[31:26];
    assign w_rs     = r_ir_q[25:21];
    assign w_rt     = r_ir_q[20:16];
    assign w_rd     = r_ir_q[15:11];
    assign w_shamt  = r_ir_q[10:6];
    assign w_funct  = r_ir_q[5:0];
    assign w_pc4    = r_pc_q + 32'd4;
    assign w_pc_oor = {2'b00, r_pc_q[31:2]} >= c_DEPTH;

    always_comb begin
        w_alu_d     = '0;
        w_pc_d      = w_pc4;
        w_is_branch = 1'b0;
        w_r_ok      = 1'b1;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_ADD: w_alu_d = r_a_q + r_b_q;
                    c_FN_SUB: w_alu_d = r_a_q - r_b_q;
                    c_FN_AND: w_alu_d = r_a_q & r_b_q;
                    c_FN_OR:  w_alu_d = r_a_q | r_b_q;
                    c_FN_SLT: w_alu_d = {31'b0, $signed(r_a_q) < $signed(r_b_q)};
                    c_FN_SLL: w_alu_d = r_b_q << w_shamt;
                    c_FN_SRL: w_alu_d = r_b_q >> w_shamt;
                    default:  w_r_ok  = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_LW, c_OP_SW: w_alu_d = r_a_q + r_imm_q;
            c_OP_ORI: w_alu_d = r_a_q | {16'b0, r_ir_q[15:0]};
            c_OP_LUI: w_alu_d = {r_ir_q[15:0], 16'b0};
            c_OP_BEQ, c_OP_BNE: begin
                w_alu_d     = r_a_q - r_b_q;
                w_is_branch = 1'b1;
                if ((r_a_q == r_b_q) == (w_op == c_OP_BEQ))
                    w_pc_d = w_pc4 + {r_imm_q[29:0], 2'b00};
            end
            c_OP_J: begin
                w_is_branch = 1'b1;
                w_pc_d      = {w_pc4[31:28], r_ir_q[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Writeback selection; lw from a non-port address returns 0.
    always_comb begin
        w_wb_en   = 1'b0;
        w_wb_addr = w_rt;
        w_wb_data = r_alu_q;
        case (w_op)
            c_OP_RTYPE: begin
                w_wb_en   = w_r_ok;
                w_wb_addr = w_rd;
            end
            c_OP_ADDI, c_OP_ORI, c_OP_LUI: w_wb_en = 1'b1;
            c_OP_LW: begin
                w_wb_en   = 1'b1;
                w_wb_data = (r_alu_q == c_PORT_IN_ADDR) ? w_port_val : 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= S_FETCH;
            r_pc_q       <= RESET_PC;
            r_ir_q       <= '0;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_imm_q      <= '0;
            r_alu_q      <= '0;
            r_port_out_q <= '0;
            r_halted_q   <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf_q[i] <= '0;
        end else if (run) begin
            case (r_state_q)
                S_FETCH: begin
                    if (w_pc_oor) begin
                        r_state_q  <= S_HALT;
                        r_halted_q <= 1'b1;
                    end else begin
                        r_ir_q    <= instr_data;
                        r_state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a_q     <= r_rf_q[w_rs];
                    r_b_q     <= r_rf_q[w_rt];
                    r_imm_q   <= {{16{r_ir_q[15]}}, r_ir_q[15:0]};
                    r_state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_alu_q <= w_alu_d;
                    if (w_is_branch) begin
                        r_pc_q    <= w_pc_d;
                        r_state_q <= S_FETCH;
                    end else begin
                        r_state_q <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (w_wb_en && (w_wb_addr != 5'd0)) r_rf_q[w_wb_addr] <= w_wb_data;
                    if ((w_op == c_OP_SW) && (r_alu_q == c_PORT_OUT_ADDR)) r_port_out_q <= r_b_q;
                    r_pc_q    <= w_pc4;
                    r_state_q <= S_FETCH;
                end
                S_HALT:  ;
                default: r_state_q <= S_FETCH;
            endcase
        end
    end

    assign instr_addr     = r_pc_q;
    assign port_out       = r_port_out_q;
    assign alu_result_out = r_alu_q;
    assign halted         = r_halted_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_core
// Brief    : Directed program bench for mips_multicycle_core with a scoreboard
//            of expected values popped at each observation point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset, run, reset_s, run_s;
    logic [31:0] instr_addr, instr_data, port_out, alu_result_out;
    logic [31:0] instr_addr_s, port_out_s, alu_result_out_s;
    logic [7:0]  port_in;
    logic        halted, halted_s;
    logic [31:0] imem [0:31];

    int          n_pass  = 0;
    int          n_total = 0;
    string       sb_tag [$];
    logic [31:0] sb_exp [$];

    always #5 clk = ~clk;

    assign instr_data = (instr_addr[31:7] == 25'd0) ? imem[instr_addr[6:2]] : 32'h0;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .run(run),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .port_in(port_in), .port_out(port_out),
        .alu_result_out(alu_result_out), .halted(halted)
    );

    // Small-memory instance fed only NOPs (all-zero words) for the halt boundary.
    mips_multicycle_core #(.MEMORY_DEPTH(4)) dut_small (
        .clk(clk), .reset(reset_s), .run(run_s),
        .instr_addr(instr_addr_s), .instr_data(32'h0),
        .port_in(port_in), .port_out(port_out_s),
        .alu_result_out(alu_result_out_s), .halted(halted_s)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string t, input logic [31:0] v);
        sb_tag.push_back(t);
        sb_exp.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        bit          have;
        have  = (sb_exp.size() != 0);
        tag   = "sb_empty";
        exp_v = 32'h0;
        if (have) begin
            tag   = sb_tag.pop_front();
            exp_v = sb_exp.pop_front();
        end
        n_total++;
        assert (have && (obs === exp_v)) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 32'h0;
        imem[0]  = 32'h2008_0005;  // addi $8,$0,5
        imem[1]  = 32'h2009_0005;  // addi $9,$0,5
        imem[2]  = 32'h1109_0002;  // beq  $8,$9,+2  (taken -> 20)
        imem[3]  = 32'h2008_0063;  // skipped
        imem[4]  = 32'h2008_0063;  // skipped
        imem[5]  = 32'h3C01_FFFF;  // lui  $1,0xFFFF
        imem[6]  = 32'hAC28_0000;  // sw   $8,0($1)
        imem[7]  = 32'h2009_0006;  // addi $9,$0,6
        imem[8]  = 32'h1109_0002;  // beq  $8,$9,+2  (not taken)
        imem[9]  = 32'h2008_005A;  // addi $8,$0,0x5A
        imem[10] = 32'hAC28_0000;  // sw   $8,0($1)
        imem[11] = 32'h8C2A_0004;  // lw   $10,4($1)
        imem[12] = 32'hAC2A_0000;  // sw   $10,0($1)
        imem[13] = 32'h0109_5822;  // sub  $11,$8,$9
        imem[14] = 32'h200D_FFFF;  // addi $13,$0,-1
        imem[15] = 32'h01A8_602A;  // slt  $12,$13,$8
        imem[16] = 32'h0008_7100;  // sll  $14,$8,4
        imem[17] = 32'h1509_0001;  // bne  $8,$9,+1  (taken -> 76)
        imem[18] = 32'h2008_0063;  // skipped
        imem[19] = 32'hFC00_0000;  // unsupported opcode
        imem[20] = 32'hAC2B_0000;  // sw   $11,0($1)
        imem[21] = 32'h2000_0009;  // addi $0,$0,9
        imem[22] = 32'h200F_0003;  // addi $15,$0,3
        imem[23] = 32'h0800_001A;  // j    104
        imem[26] = 32'h2008_0007;  // addi $8,$0,7

        reset = 1'b1; run = 1'b1; reset_s = 1'b1; run_s = 1'b1; port_in = 8'hA5;
        tick(2);
        reset = 1'b0;
        expect_v("rst_pc", 32'h0);   expect_v("rst_port_out", 32'h0);
        expect_v("rst_alu", 32'h0);  expect_v("rst_halted", 32'h0);
        chk(instr_addr); chk(port_out); chk(alu_result_out); chk({31'b0, halted});

        expect_v("addi_alu", 32'd5); expect_v("addi_pc", 32'd4);
        tick(4); chk(alu_result_out); chk(instr_addr);
        tick(4);
        expect_v("beq_taken_pc", 32'd20);
        tick(3); chk(instr_addr);
        expect_v("lui_alu", 32'hFFFF_0000);
        tick(4); chk(alu_result_out);
        expect_v("sw_port_out", 32'd5);
        tick(4); chk(port_out);
        tick(4);
        expect_v("beq_untaken_pc", 32'd36);
        tick(3); chk(instr_addr);
        tick(4);
        expect_v("sw_5a", 32'h0000_005A);
        tick(4); chk(port_out);
        tick(4);
        expect_v("lw_port_in", 32'h0000_00A5);
        tick(4); chk(port_out);
        expect_v("sub_alu", 32'h0000_0054);
        tick(4); chk(alu_result_out);
        expect_v("addi_neg_alu", 32'hFFFF_FFFF);
        tick(4); chk(alu_result_out);
        expect_v("slt_signed", 32'd1);
        tick(4); chk(alu_result_out);
        expect_v("sll_alu", 32'h0000_05A0);
        tick(4); chk(alu_result_out);
        expect_v("bne_taken_pc", 32'd76);
        tick(3); chk(instr_addr);
        expect_v("nop_not_3cyc", 32'd76); expect_v("nop_4cyc", 32'd80);
        tick(3); chk(instr_addr);
        tick(1); chk(instr_addr);
        expect_v("sub_wb_port", 32'h0000_0054);
        tick(4); chk(port_out);
        tick(4);
        expect_v("r0_reads_zero", 32'd3);
        tick(4); chk(alu_result_out);
        expect_v("j_pc", 32'd104);
        tick(3); chk(instr_addr);

        // Reset lands while addi $8,$0,7 sits in WRITEBACK.
        expect_v("pre_rst_alu", 32'd7);
        tick(3); chk(alu_result_out);
        reset = 1'b1;
        imem[0] = 32'h210F_0001;     // addi $15,$8,1
        tick(1);
        reset = 1'b0;
        expect_v("wb_rst_pc", 32'h0); expect_v("wb_rst_port", 32'h0);
        chk(instr_addr); chk(port_out);
        tick(2);
        run = 1'b0;
        expect_v("freeze_pc", 32'h0); expect_v("freeze_alu", 32'h0);
        tick(5); chk(instr_addr); chk(alu_result_out);
        run = 1'b1;
        expect_v("r8_abandoned", 32'd1);
        tick(1); chk(alu_result_out);
        expect_v("resume_pc", 32'd4);
        tick(1); chk(instr_addr);

        // Halt boundary on the 4-word instance.
        reset_s = 1'b0;
        expect_v("small_pc16", 32'd16); expect_v("small_not_halted", 32'd0);
        tick(16); chk(instr_addr_s); chk({31'b0, halted_s});
        expect_v("small_halted", 32'd1);
        tick(1); chk({31'b0, halted_s});
        expect_v("halt_pc_hold", 32'd16); expect_v("halt_sticky", 32'd1);
        tick(10); chk(instr_addr_s); chk({31'b0, halted_s});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
